wram_access_arbiter: RTL and testbench

- Shares the single working-RAM port (0xC000-0xDFFF, banked by SVBK downstream) between two requesters: the CPU memory path and a DMA engine (OAM DMA / HDMA source reads).
- Serialises requests, drives the WRAM strobes, address and data bus for a fixed access window, and returns read data with a one-cycle acknowledge.
- Also folds echo RAM (0xE000-0xFDFF) onto WRAM and answers out-of-range requests without touching memory.

---
 rtl/wram_access_arbiter.sv | 145 ++++++++++++++
 tb/tb_wram_access_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wram_access_arbiter.sv
// Working-RAM port arbiter: serialises CPU and DMA requests onto the single WRAM port,
// folds echo RAM onto 0xC000-0xDFFF and answers out-of-range requests with open bus.
module wram_access_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned STARVE_LIMIT  = 4,
    parameter logic [7:0]  OPEN_BUS      = 8'hFF
) (
    input  logic        I_CLK,
    input  logic        I_RESET_L,
    input  logic        I_CPU_REQ,
    input  logic [15:0] I_CPU_ADDR,
    input  logic        I_CPU_WE,
    input  logic [7:0]  I_CPU_WDATA,
    output logic        O_CPU_ACK,
    output logic [7:0]  O_CPU_RDATA,
    input  logic        I_DMA_REQ,
    input  logic [15:0] I_DMA_ADDR,
    input  logic        I_DMA_WE,
    input  logic [7:0]  I_DMA_WDATA,
    output logic        O_DMA_ACK,
    output logic [7:0]  O_DMA_RDATA,
    output logic [15:0] O_WRAM_ADDR,
    inout  logic [7:0]  IO_WRAM_DATA,
    output logic        O_WRAM_WE_L,
    output logic        O_WRAM_RE_L,
    output logic        O_BUSY,
    output logic        O_OWNER_DMA
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT   = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t      state;
    logic [3:0]  cnt;
    logic [3:0]  starve_cnt;
    logic        cur_we;
    logic [7:0]  wdata_q;
    logic        drive;

    logic        dma_win;
    logic [15:0] sel_addr;
    logic        sel_we;
    logic [7:0]  sel_wdata;
    logic [15:0] map_addr;
    logic        in_range;

    always_comb begin
        dma_win   = I_DMA_REQ && !(I_CPU_REQ && (starve_cnt == STARVE_MAX));
        sel_addr  = dma_win ? I_DMA_ADDR  : I_CPU_ADDR;
        sel_we    = dma_win ? I_DMA_WE    : I_CPU_WE;
        sel_wdata = dma_win ? I_DMA_WDATA : I_CPU_WDATA;
        map_addr  = sel_addr;
        in_range  = 1'b1;
        // Echo window 0xE000-0xFDFF aliases WRAM by dropping address bit 13
        if (sel_addr[15:13] == 3'b110) begin
            map_addr = sel_addr;
        end else if (sel_addr >= 16'hE000 && sel_addr <= 16'hFDFF) begin
            map_addr = {sel_addr[15:14], 1'b0, sel_addr[12:0]};
        end else begin
            in_range = 1'b0;
        end
    end

    assign IO_WRAM_DATA = drive ? wdata_q : 'z;

    always_ff @(posedge I_CLK) begin
        if (!I_RESET_L) begin
            state       <= S_IDLE;
            cnt         <= '0;
            starve_cnt  <= '0;
            cur_we      <= 1'b0;
            wdata_q     <= '0;
            drive       <= 1'b0;
            O_CPU_ACK   <= 1'b0;
            O_DMA_ACK   <= 1'b0;
            O_CPU_RDATA <= '0;
            O_DMA_RDATA <= '0;
            O_WRAM_ADDR <= '0;
            O_WRAM_WE_L <= 1'b1;
            O_WRAM_RE_L <= 1'b1;
            O_BUSY      <= 1'b0;
            O_OWNER_DMA <= 1'b0;
        end else begin
            O_CPU_ACK <= 1'b0;
            O_DMA_ACK <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!I_CPU_REQ) starve_cnt <= '0;
                    if (I_CPU_REQ || I_DMA_REQ) begin
                        O_OWNER_DMA <= dma_win;
                        O_BUSY      <= 1'b1;
                        cur_we      <= sel_we;
                        wdata_q     <= sel_wdata;
                        if (!dma_win) begin
                            starve_cnt <= '0;
                        end else if (I_CPU_REQ && starve_cnt != 4'hF) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                        if (in_range) begin
                            O_WRAM_ADDR <= map_addr;
                            O_WRAM_WE_L <= !sel_we;
                            O_WRAM_RE_L <= sel_we;
                            drive       <= sel_we;
                            cnt         <= '0;
                            state       <= S_ACCESS;
                        end else begin
                            // Out-of-range: no strobe, ack straight away with open-bus data
                            O_CPU_ACK <= !dma_win;
                            O_DMA_ACK <= dma_win;
                            if (!sel_we && dma_win)  O_DMA_RDATA <= OPEN_BUS;
                            if (!sel_we && !dma_win) O_CPU_RDATA <= OPEN_BUS;
                            state <= S_DONE;
                        end
                    end
                end
                S_ACCESS: begin
                    if (cnt == LAST_CNT) begin
                        O_WRAM_WE_L <= 1'b1;
                        O_WRAM_RE_L <= 1'b1;
                        drive       <= 1'b0;
                        O_CPU_ACK   <= !O_OWNER_DMA;
                        O_DMA_ACK   <= O_OWNER_DMA;
                        if (!cur_we && O_OWNER_DMA)  O_DMA_RDATA <= IO_WRAM_DATA;
                        if (!cur_we && !O_OWNER_DMA) O_CPU_RDATA <= IO_WRAM_DATA;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    O_BUSY <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wram_access_arbiter.sv
// Bench for wram_access_arbiter: behavioural WRAM on the bus, transaction-level
// reference model (address map, memory contents, starvation rule) and scenario tasks.
module tb_wram_access_arbiter;

    localparam int unsigned AC = 2;
    localparam int unsigned SL = 4;
    localparam logic [7:0]  OB = 8'hFF;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
    logic [15:0] cpu_addr = '0, dma_addr = '0;
    logic [7:0]  cpu_wdata = '0, dma_wdata = '0;
    logic        cpu_ack, dma_ack, we_l, re_l, busy, owner;
    logic [7:0]  cpu_rdata, dma_rdata;
    logic [15:0] wram_addr;
    wire  [7:0]  wram_data;

    always #5 clk = ~clk;

    wram_access_arbiter #(.ACCESS_CYCLES(AC), .STARVE_LIMIT(SL), .OPEN_BUS(OB)) dut (
        .I_CLK(clk), .I_RESET_L(reset_l),
        .I_CPU_REQ(cpu_req), .I_CPU_ADDR(cpu_addr), .I_CPU_WE(cpu_we), .I_CPU_WDATA(cpu_wdata),
        .O_CPU_ACK(cpu_ack), .O_CPU_RDATA(cpu_rdata),
        .I_DMA_REQ(dma_req), .I_DMA_ADDR(dma_addr), .I_DMA_WE(dma_we), .I_DMA_WDATA(dma_wdata),
        .O_DMA_ACK(dma_ack), .O_DMA_RDATA(dma_rdata),
        .O_WRAM_ADDR(wram_addr), .IO_WRAM_DATA(wram_data),
        .O_WRAM_WE_L(we_l), .O_WRAM_RE_L(re_l), .O_BUSY(busy), .O_OWNER_DMA(owner)
    );

    // Behavioural 8 KB WRAM: drives the bus while read strobe is low, writes on clock edges
    logic [7:0] wram_mem [0:8191];
    assign wram_data = (!re_l) ? wram_mem[wram_addr[12:0]] : 'z;
    always @(posedge clk) if (!we_l) wram_mem[wram_addr[12:0]] <= wram_data;

    int n_cmp = 0;
    int n_fail = 0;

    bit   [7:0]  model_mem [int];
    logic [15:0] written_q [$];
    logic [7:0]  exp_cpu_rd = 8'h00;
    logic [7:0]  exp_dma_rd = 8'h00;

    function automatic bit ref_map(input logic [15:0] a, output logic [15:0] m);
        m = a;
        if (a >= 16'hC000 && a < 16'hE000) return 1'b1;
        if (a >= 16'hE000 && a < 16'hFE00) begin
            m = a - 16'h2000;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void ref_txn(input bit dma, input logic [15:0] a, input bit we,
                                    input logic [7:0] wd, output int lat, output int wc,
                                    output int rc, output bit inr, output logic [15:0] m,
                                    output logic [7:0] rd);
        inr = ref_map(a, m);
        rd  = dma ? exp_dma_rd : exp_cpu_rd;
        if (!inr) begin
            lat = 1; wc = 0; rc = 0;
            if (!we) rd = OB;
        end else begin
            lat = int'(AC) + 1;
            wc  = we ? int'(AC) : 0;
            rc  = we ? 0 : int'(AC);
            if (we) begin
                model_mem[int'(m)] = wd;
                written_q.push_back(m);
            end else begin
                rd = model_mem.exists(int'(m)) ? model_mem[int'(m)] : 8'h00;
            end
        end
        if (dma) exp_dma_rd = rd;
        else     exp_cpu_rd = rd;
    endfunction

    task automatic run_txn(input bit dma, input logic [15:0] a, input bit we, input logic [7:0] wd,
                           output int lat, output int wc, output int rc, output logic [15:0] seen,
                           output logic [7:0] rd, output logic own, output int other);
        lat = 0; wc = 0; rc = 0; seen = '0; rd = '0; own = 1'b0; other = 0;
        @(negedge clk);
        if (dma) begin dma_req = 1'b1; dma_addr = a; dma_we = we; dma_wdata = wd; end
        else     begin cpu_req = 1'b1; cpu_addr = a; cpu_we = we; cpu_wdata = wd; end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!we_l) begin wc++; seen = wram_addr; end
            if (!re_l) begin rc++; seen = wram_addr; end
            if (dma ? cpu_ack : dma_ack) other++;
            if (dma ? dma_ack : cpu_ack) begin
                lat = k;
                rd  = dma ? dma_rdata : cpu_rdata;
                own = owner;
                break;
            end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
    endtask

    task automatic test_reset();
        reset_l = 1'b0;
        repeat (3) @(negedge clk);
        reset_l = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({we_l, re_l, cpu_ack, dma_ack, busy, owner} !== 6'b110000) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: we/re/cack/dack/busy/own got %b want 110000",
                         i, {we_l, re_l, cpu_ack, dma_ack, busy, owner});
            end
        end
        n_cmp++;
        if ({cpu_rdata, dma_rdata, wram_addr} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_regs: rdata/addr got %h want 00000000", {cpu_rdata, dma_rdata, wram_addr});
        end
    endtask

    task automatic test_cpu_write_read();
        int lat, wc, rc, oth, elat, ewc, erc;
        logic [15:0] seen, em;
        logic [7:0] rd, erd;
        logic own;
        bit inr;
        ref_txn(1'b0, 16'hC010, 1'b1, 8'h5A, elat, ewc, erc, inr, em, erd);
        run_txn(1'b0, 16'hC010, 1'b1, 8'h5A, lat, wc, rc, seen, rd, own, oth);
        n_cmp++;
        if (lat !== 3 || wc !== 2 || rc !== 0 || seen !== 16'hC010) begin
            n_fail++;
            $display("FAIL cpu_write: lat/we/re/addr got %0d/%0d/%0d/%h want 3/2/0/c010", lat, wc, rc, seen);
        end
        ref_txn(1'b0, 16'hC010, 1'b0, 8'h00, elat, ewc, erc, inr, em, erd);
        run_txn(1'b0, 16'hC010, 1'b0, 8'h00, lat, wc, rc, seen, rd, own, oth);
        n_cmp++;
        if (lat !== 3 || wc !== 0 || rc !== 2 || rd !== 8'h5A || own !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_read: lat/we/re/rdata/own got %0d/%0d/%0d/%h/%b want 3/0/2/5a/0",
                     lat, wc, rc, rd, own);
        end
    endtask

    // Fixed boundary table followed by random traffic, all checked against the model
    task automatic test_address_map();
        logic [15:0] tab_addr [10] = '{16'hE010, 16'h8000, 16'hDFFF, 16'hFDFF, 16'hDDFF,
                                        16'hFE00, 16'hBFFF, 16'hFE00, 16'hE010, 16'hFFFF};
        bit          tab_we   [10] = '{0, 0, 1, 1, 0, 0, 0, 1, 0, 0};
        bit          tab_dma  [10] = '{0, 0, 0, 1, 1, 0, 1, 0, 1, 1};
        for (int i = 0; i < 50; i++) begin
            int lat, wc, rc, oth, elat, ewc, erc;
            logic [15:0] a, seen, em;
            logic [7:0] wd, rd, erd, other_rd, other_exp;
            logic own;
            bit inr, dma, we;
            wd = 8'($urandom);
            if (i < 10) begin
                a = tab_addr[i]; we = tab_we[i]; dma = tab_dma[i];
            end else begin
                dma = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 3))
                    0: begin we = 1'b1; a = 16'hC000 + 16'($urandom_range(0, 16'h1FFF)); end
                    1: begin we = 1'b1; a = 16'hE000 + 16'($urandom_range(0, 16'h1DFF)); end
                    2: begin
                        we = 1'($urandom_range(0, 1));
                        a  = $urandom_range(0, 1) ? 16'($urandom_range(0, 16'hBFFF))
                                                  : 16'hFE00 + 16'($urandom_range(0, 16'h01FF));
                    end
                    default: begin
                        we = 1'b0;
                        a  = written_q[$urandom_range(0, written_q.size() - 1)];
                        if (a < 16'hDE00 && $urandom_range(0, 1) == 1) a = a + 16'h2000;
                    end
                endcase
            end
            other_exp = dma ? exp_cpu_rd : exp_dma_rd;
            ref_txn(dma, a, we, wd, elat, ewc, erc, inr, em, erd);
            run_txn(dma, a, we, wd, lat, wc, rc, seen, rd, own, oth);
            other_rd = dma ? cpu_rdata : dma_rdata;
            n_cmp++;
            if (lat !== elat || wc !== ewc || rc !== erc || own !== dma || oth !== 0) begin
                n_fail++;
                $display("FAIL map_timing #%0d a=%h: lat/we/re/own/oth got %0d/%0d/%0d/%b/%0d want %0d/%0d/%0d/%b/0",
                         i, a, lat, wc, rc, own, oth, elat, ewc, erc, dma);
            end
            if (inr) begin
                n_cmp++;
                if (seen !== em) begin
                    n_fail++;
                    $display("FAIL map_addr #%0d a=%h: got %h want %h", i, a, seen, em);
                end
            end
            n_cmp++;
            if (rd !== erd || other_rd !== other_exp) begin
                n_fail++;
                $display("FAIL map_rdata #%0d a=%h: owner/other got %h/%h want %h/%h",
                         i, a, rd, other_rd, erd, other_exp);
            end
        end
    endtask

    task automatic test_starvation();
        int s = 0;
        int n_ack = 0;
        int last_k = 0;
        logic [15:0] a;
        logic [7:0] v;
        a = written_q[0];
        v = model_mem.exists(int'(a)) ? model_mem[int'(a)] : 8'h00;
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = a; cpu_we = 1'b0;
        dma_req = 1'b1; dma_addr = a; dma_we = 1'b0;
        for (int k = 1; k <= 200 && n_ack < 6; k++) begin
            @(negedge clk);
            if (cpu_ack || dma_ack) begin
                bit exp_dma;
                exp_dma = (s != int'(SL));
                s = exp_dma ? s + 1 : 0;
                n_cmp++;
                if (dma_ack !== exp_dma || cpu_ack !== !exp_dma || owner !== exp_dma) begin
                    n_fail++;
                    $display("FAIL starve_grant #%0d: dack/cack/own got %b/%b/%b want dma=%b",
                             n_ack, dma_ack, cpu_ack, owner, exp_dma);
                end
                n_cmp++;
                if ((k - last_k) !== (n_ack == 0 ? int'(AC) + 1 : int'(AC) + 2)
                    || (exp_dma ? dma_rdata : cpu_rdata) !== v) begin
                    n_fail++;
                    $display("FAIL starve_spacing #%0d: gap %0d rdata %h, want gap %0d rdata %h", n_ack,
                             k - last_k, exp_dma ? dma_rdata : cpu_rdata,
                             n_ack == 0 ? AC + 1 : AC + 2, v);
                end
                last_k = k;
                n_ack++;
            end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        exp_cpu_rd = v;
        exp_dma_rd = v;
        n_cmp++;
        if (n_ack !== 6) begin
            n_fail++;
            $display("FAIL starve_timeout: acks got %0d want 6", n_ack);
        end
    endtask

    task automatic test_withdrawal();
        int lat, wc, rc, oth, elat, ewc, erc;
        int dack = 0, cack = 0, we_cnt = 0, re_cnt = 0, dack_k = 0;
        logic [15:0] seen, em, a;
        logic [7:0] rd, erd;
        logic own;
        bit inr;
        ref_txn(1'b0, 16'hC1F0, 1'b1, 8'h33, elat, ewc, erc, inr, em, erd);
        run_txn(1'b0, 16'hC1F0, 1'b1, 8'h33, lat, wc, rc, seen, rd, own, oth);
        a = written_q[0];
        ref_txn(1'b1, a, 1'b0, 8'h00, elat, ewc, erc, inr, em, erd);
        @(negedge clk);
        dma_req = 1'b1; dma_addr = a; dma_we = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (!we_l) we_cnt++;
            if (!re_l) re_cnt++;
            if (cpu_ack) cack++;
            if (dma_ack) begin dack++; dack_k = k; end
            if (k == 1) begin
                dma_req = 1'b0;
                cpu_req = 1'b1; cpu_addr = 16'hC1F0; cpu_we = 1'b1; cpu_wdata = 8'h77;
            end
            if (k == 2) cpu_req = 1'b0;
        end
        n_cmp++;
        if (dack !== 1 || dack_k !== 3 || cack !== 0 || we_cnt !== 0 || re_cnt !== 2) begin
            n_fail++;
            $display("FAIL withdraw: dack/at/cack/we/re got %0d/%0d/%0d/%0d/%0d want 1/3/0/0/2",
                     dack, dack_k, cack, we_cnt, re_cnt);
        end
        n_cmp++;
        if (dma_rdata !== erd) begin
            n_fail++;
            $display("FAIL withdraw_rdata: got %h want %h", dma_rdata, erd);
        end
        ref_txn(1'b0, 16'hC1F0, 1'b0, 8'h00, elat, ewc, erc, inr, em, erd);
        run_txn(1'b0, 16'hC1F0, 1'b0, 8'h00, lat, wc, rc, seen, rd, own, oth);
        n_cmp++;
        if (rd !== 8'h33 || lat !== 3) begin
            n_fail++;
            $display("FAIL withdraw_nowrite: rdata/lat got %h/%0d want 33/3", rd, lat);
        end
    endtask

    task automatic test_reset_mid_access();
        int lat, wc, rc, oth, elat, ewc, erc;
        logic [15:0] seen, em;
        logic [7:0] rd, erd;
        logic own;
        bit inr;
        int bad = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 16'hC2F0; cpu_we = 1'b1; cpu_wdata = 8'hA5;
        @(negedge clk);
        n_cmp++;
        if (we_l !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_access: we_l/busy got %b/%b want 0/1", we_l, busy);
        end
        reset_l = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({we_l, re_l, cpu_ack, dma_ack, busy, owner} !== 6'b110000 || {cpu_rdata, dma_rdata} !== 16'h0) begin
            n_fail++;
            $display("FAIL midrst_abort: we/re/cack/dack/busy/own got %b rdata %h want 110000 0000",
                     {we_l, re_l, cpu_ack, dma_ack, busy, owner}, {cpu_rdata, dma_rdata});
        end
        reset_l = 1'b1;
        exp_cpu_rd = 8'h00;
        exp_dma_rd = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (cpu_ack || dma_ack || !we_l || !re_l || busy) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL midrst_quiet: activity cycles got %0d want 0", bad);
        end
        ref_txn(1'b0, written_q[0], 1'b0, 8'h00, elat, ewc, erc, inr, em, erd);
        run_txn(1'b0, written_q[0], 1'b0, 8'h00, lat, wc, rc, seen, rd, own, oth);
        n_cmp++;
        if (lat !== elat || rd !== erd || dma_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_recover: lat/rdata/dma_rdata got %0d/%h/%h want %0d/%h/00",
                     lat, rd, dma_rdata, elat, erd);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cpu_write_read();
        test_address_map();
        test_starvation();
        test_withdrawal();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
